// File: rtl/dma_pkg.sv
// Shared constants, FSM state encoding and helpers for the DMA priority arbiter.
package dma_pkg;

  localparam int DMA_NCH = 4;
  localparam int DMA_CW  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // NCH is a power of two, so the natural CW-bit wrap gives (id+1) mod NCH.
  function automatic logic [DMA_CW-1:0] next_ptr(input logic [DMA_CW-1:0] id);
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Stateless priority resolver: first eligible channel at or after the pointer wins.
module dma_rr_pick
  import dma_pkg::*;
#(
  parameter int NCH = DMA_NCH,
  parameter int CW  = DMA_CW
) (
  input  logic [NCH-1:0] eligible,
  input  logic [CW-1:0]  pointer,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  id
);

  logic          found_s;
  logic [CW-1:0] idx_s;

  // Scan channels starting at the pointer, wrapping modulo NCH.
  always_comb begin
    grant   = '0;
    id      = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx_s = pointer + CW'(i);
      if (!found_s && eligible[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        id           = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: hold-request handshake with the CPU, fixed or rotating
// priority, single-transfer or demand mode. All outputs are registered.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NCH = DMA_NCH,
  parameter int CW  = DMA_CW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] dreq,
  input  logic [NCH-1:0] mask,
  input  logic           ctrl_disable,
  input  logic           rot_pri,
  input  logic           demand,
  input  logic           hlda,
  input  logic           xfer_done,
  output logic           hrq,
  output logic [NCH-1:0] dack,
  output logic [CW-1:0]  ch_id,
  output logic           grant_valid
);

  arb_state_t     state_r, next_state_s;
  logic [CW-1:0]  ptr_r, ptr_nx_s, pick_ptr_s, pick_id_s;
  logic [NCH-1:0] eligible_s, pick_grant_s;
  logic           hrq_r, hrq_nx_s, gv_r, gv_nx_s;
  logic [NCH-1:0] dack_r, dack_nx_s;
  logic [CW-1:0]  ch_id_r, ch_id_nx_s;

  // Eligible channel set and the pointer handed to the resolver.
  always_comb begin
    eligible_s = '0;
    pick_ptr_s = '0;
    if (ctrl_disable) begin
      eligible_s = '0;
    end else begin
      eligible_s = dreq & ~mask;
    end
    if (rot_pri) begin
      pick_ptr_s = ptr_r;
    end else begin
      pick_ptr_s = '0;
    end
  end

  dma_rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .eligible (eligible_s),
    .pointer  (pick_ptr_s),
    .grant    (pick_grant_s),
    .id       (pick_id_s)
  );

  // State and rotation-pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ptr_r   <= '0;
    end else begin
      state_r <= next_state_s;
      ptr_r   <= ptr_nx_s;
    end
  end

  // Next-state logic; the pointer only advances on a normal GRANT exit.
  always_comb begin
    next_state_s = state_r;
    ptr_nx_s     = ptr_r;
    case (state_r)
      IDLE: begin
        if (|eligible_s) next_state_s = REQ;
        else             next_state_s = IDLE;
      end
      REQ: begin
        if (hlda) begin
          if (|eligible_s) next_state_s = GRANT;
          else             next_state_s = RELEASE;
        end else begin
          next_state_s = REQ;
        end
      end
      GRANT: begin
        if (!hlda) begin
          next_state_s = RELEASE;
        end else if (xfer_done) begin
          if (demand && dreq[ch_id_r]) begin
            next_state_s = GRANT;
          end else begin
            next_state_s = RELEASE;
            if (rot_pri) ptr_nx_s = next_ptr(ch_id_r);
            else         ptr_nx_s = ptr_r;
          end
        end else begin
          next_state_s = GRANT;
        end
      end
      RELEASE: begin
        if (!hlda) next_state_s = IDLE;
        else       next_state_s = RELEASE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle; the grant is frozen for all of GRANT.
  always_comb begin
    hrq_nx_s   = (next_state_s == REQ) || (next_state_s == GRANT);
    dack_nx_s  = '0;
    ch_id_nx_s = '0;
    gv_nx_s    = 1'b0;
    if (next_state_s == GRANT) begin
      gv_nx_s = 1'b1;
      if (state_r == REQ) begin
        dack_nx_s  = pick_grant_s;
        ch_id_nx_s = pick_id_s;
      end else begin
        dack_nx_s  = dack_r;
        ch_id_nx_s = ch_id_r;
      end
    end else begin
      gv_nx_s = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hrq_r   <= 1'b0;
      dack_r  <= '0;
      ch_id_r <= '0;
      gv_r    <= 1'b0;
    end else begin
      hrq_r   <= hrq_nx_s;
      dack_r  <= dack_nx_s;
      ch_id_r <= ch_id_nx_s;
      gv_r    <= gv_nx_s;
    end
  end

  assign hrq         = hrq_r;
  assign dack        = dack_r;
  assign ch_id       = ch_id_r;
  assign grant_valid = gv_r;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Table-driven bench for dma_priority_arbiter plus a hand-written reset sequence.
module tb_dma_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dreq, mask;
  logic       ctrl_disable, rot_pri, demand, hlda, xfer_done;
  logic       hrq, grant_valid;
  logic [3:0] dack;
  logic [1:0] ch_id;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] d;
    logic [3:0] m;
    logic       cd;
    logic       rp;
    logic       dm;
    logic       hl;
    logic       xd;
    logic       e_hrq;
    logic [3:0] e_dack;
    logic [1:0] e_id;
    logic       e_gv;
  } vec_t;

  vec_t vq[$];

  dma_priority_arbiter #(.NCH(4), .CW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .dreq         (dreq),
    .mask         (mask),
    .ctrl_disable (ctrl_disable),
    .rot_pri      (rot_pri),
    .demand       (demand),
    .hlda         (hlda),
    .xfer_done    (xfer_done),
    .hrq          (hrq),
    .dack         (dack),
    .ch_id        (ch_id),
    .grant_valid  (grant_valid)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic [3:0] d, input logic [3:0] m, input logic cd,
                         input logic rp, input logic dm, input logic hl, input logic xd,
                         input logic eh, input logic [3:0] ed, input logic [1:0] ei,
                         input logic eg);
    vec_t v;
    v.d = d; v.m = m; v.cd = cd; v.rp = rp; v.dm = dm; v.hl = hl; v.xd = xd;
    v.e_hrq = eh; v.e_dack = ed; v.e_id = ei; v.e_gv = eg;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic eh, input logic [3:0] ed,
                          input logic [1:0] ei, input logic eg);
    chk({tag, "_hrq"},  {7'd0, hrq},         {7'd0, eh});
    chk({tag, "_dack"}, {4'd0, dack},        {4'd0, ed});
    chk({tag, "_id"},   {6'd0, ch_id},       {6'd0, ei});
    chk({tag, "_gv"},   {7'd0, grant_valid}, {7'd0, eg});
  endtask

  initial begin
    logic [3:0] oh;
    reset = 1'b0; dreq = 4'd0; mask = 4'd0; ctrl_disable = 1'b0;
    rot_pri = 1'b0; demand = 1'b0; hlda = 1'b0; xfer_done = 1'b0;

    // Fixed priority: 1010 -> ch1, hlda two cycles after hrq
    add_vec(4'b1010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b1010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b1010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1);
    add_vec(4'b1010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1);
    add_vec(4'b1010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    // Rotating, all requesting: ch0, ch1, ch2, ch3, ch0
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      add_vec(4'b1111, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
      add_vec(4'b1111, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, oh, 2'(k % 4), 1'b1);
      add_vec(4'b1111, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
      add_vec(4'b1111, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    end
    // Masked and disabled requests never raise hrq
    add_vec(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0100, 4'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0100, 4'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    // Demand mode on ch2, grant frozen against mask/disable/other dreq changes
    add_vec(4'b0100, 4'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0100, 4'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
    add_vec(4'b0100, 4'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    add_vec(4'b0100, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
    add_vec(4'b0100, 4'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    add_vec(4'b0101, 4'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
    add_vec(4'b0100, 4'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    add_vec(4'b0000, 4'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
    add_vec(4'b0000, 4'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    // Request withdrawn before hlda, then hlda dropped mid-GRANT
    add_vec(4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1);
    add_vec(4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add_vec(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      dreq = vq[i].d; mask = vq[i].m; ctrl_disable = vq[i].cd; rot_pri = vq[i].rp;
      demand = vq[i].dm; hlda = vq[i].hl; xfer_done = vq[i].xd;
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vq[i].e_hrq, vq[i].e_dack, vq[i].e_id, vq[i].e_gv);
    end

    // Reset mid-GRANT of ch3 in rotating mode; pointer must return to ch0
    @(negedge clk);
    dreq = 4'b1000; mask = 4'd0; ctrl_disable = 1'b0; rot_pri = 1'b1;
    demand = 1'b0; hlda = 1'b0; xfer_done = 1'b0;
    @(posedge clk); #1;
    chk_outs("rst_req", 1'b1, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    hlda = 1'b1;
    @(posedge clk); #1;
    chk_outs("rst_grant3", 1'b1, 4'b1000, 2'd3, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("rst_async", 1'b0, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1; dreq = 4'b1001; hlda = 1'b0;
    @(posedge clk); #1;
    chk_outs("post_req", 1'b1, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    hlda = 1'b1;
    @(posedge clk); #1;
    chk_outs("post_grant0", 1'b1, 4'b0001, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
